// File: rtl/cla_seq_add_ctrl.sv
// Slice-serial add/subtract: one SLICE-bit carry-lookahead adder reused per clock,
// LSB slice first, carry registered between slices, valid/ready on both sides.
module cla_seq_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_width
            $error("cla_seq_add_ctrl: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_sum_slice;
    logic               w_cout_slice;
    logic               w_ovf;

    // Generate/propagate carry-lookahead slice; returns {cout, sum}.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    always_comb begin
        w_a_slice                   = r_a[int'(r_idx)*SLICE +: SLICE];
        w_b_slice                   = r_b[int'(r_idx)*SLICE +: SLICE];
        {w_cout_slice, w_sum_slice} = cla_slice(w_a_slice, w_b_slice, r_carry);
        // Only meaningful on the MSB slice, where the slice sum MSB is the result MSB.
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_slice[SLICE-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= in_a;
                        r_b      <= in_sub ? ~in_b : in_b;
                        r_carry  <= in_sub;
                        r_idx    <= '0;
                        r_state  <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    out_sum[int'(r_idx)*SLICE +: SLICE] <= w_sum_slice;
                    r_carry <= w_cout_slice;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        out_cout  <= w_cout_slice;
                        out_ovf   <= w_ovf;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
